// File: rtl/dmem_pkg.sv
// Shared types and defaults for the dmem_bridge data-memory bridge.
package dmem_pkg;

  localparam int unsigned DMEM_AW       = 32;
  localparam int unsigned DMEM_DW       = 32;
  localparam int unsigned DMEM_TIMEOUT  = 255;
  localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
    logic               we;
  } req_t;

endpackage

// File: rtl/dmem_bridge_if.sv
// Request/acknowledge bus between dmem_bridge and external data memory.
interface dmem_bridge_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_we;
  logic          bus_req;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_req,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_req,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_timeout_ctr.sv
// Wait-cycle counter: cleared on a new request, counts while enabled,
// flags the cycle on which TIMEOUT waiting cycles have elapsed.
module dmem_timeout_ctr
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: MEM-stage memory port to req/ack data-memory bus with bounded wait and sticky err.
// Optional: define DMEM_POSTED_WR_EN for a one-entry posted write buffer.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned   AW       = DMEM_AW,
  parameter int unsigned   DW       = DMEM_DW,
  parameter int unsigned   TIMEOUT  = DMEM_TIMEOUT,
  parameter logic [DW-1:0] ERR_DATA = DW'(DMEM_ERR_DATA)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  inout  logic [DW-1:0] cpu_data,
  output logic          cpu_ready,
  dmem_bridge_if.master bus,
  output logic          err,
  input  logic          err_clr
);

  state_t        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rbuf;
  logic          we_q;
  logic          req_q;
  logic          any_req;
  logic          start;
  logic          busy_ack;
  logic          busy_to;
  logic          busy_exp;
  logic          req_done;
  logic          err_set;

  assign any_req = cpu_rd | cpu_wr;

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_busy_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (start),
    .en      (state == BUSY),
    .expired (busy_exp)
  );

`ifdef DMEM_POSTED_WR_EN
  // A posted write owns the bus registers while pw_busy; the FSM only issues
  // a new request once it has drained, so reads never overtake it.
  logic pw_busy;
  logic pw_ack;
  logic pw_to;
  logic pw_exp;
  logic post;

  assign post   = start & cpu_wr;
  assign pw_ack = pw_busy & bus.bus_ack;
  assign pw_to  = pw_busy & ~bus.bus_ack & pw_exp;

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_pw_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (post),
    .en      (pw_busy),
    .expired (pw_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pw_busy <= 1'b0;
    end else if (post) begin
      pw_busy <= 1'b1;
    end else if (pw_ack | pw_to) begin
      pw_busy <= 1'b0;
    end
  end

  assign req_done = busy_ack | busy_to | pw_ack | pw_to;
  assign err_set  = (start & cpu_rd & cpu_wr) | busy_to | pw_to;
`else
  assign req_done = busy_ack | busy_to;
  assign err_set  = (start & cpu_rd & cpu_wr) | busy_to;
`endif

  always_comb begin
    state_nxt = state;
    cpu_ready = 1'b0;
    start     = 1'b0;
    busy_ack  = 1'b0;
    busy_to   = 1'b0;
    unique case (state)
      IDLE: begin
        cpu_ready = ~any_req;
`ifdef DMEM_POSTED_WR_EN
        if (any_req && !pw_busy) begin
          start     = 1'b1;
          state_nxt = cpu_wr ? DONE : BUSY;
        end
`else
        if (any_req) begin
          start     = 1'b1;
          state_nxt = BUSY;
        end
`endif
      end
      BUSY: begin
        // Ack takes priority over expiry in the same cycle.
        if (bus.bus_ack) begin
          busy_ack  = 1'b1;
          state_nxt = DONE;
        end else if (busy_exp) begin
          busy_to   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        cpu_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      rbuf    <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        addr_q  <= cpu_addr & ~AW'(3);
        wdata_q <= cpu_data;
        we_q    <= cpu_wr;
        req_q   <= 1'b1;
      end else if (req_done) begin
        req_q <= 1'b0;
      end
      if (busy_ack) begin
        rbuf <= bus.bus_rdata;
      end else if (busy_to) begin
        rbuf <= ERR_DATA;
      end
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_req   = req_q;

  assign cpu_data = (state == DONE && !we_q) ? rbuf : 'z;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: vector table on a default instance plus
// hand sequences (reset, timeout, ack-on-expiry) on a TIMEOUT=4 instance.
module tb_dmem_bridge;

`ifdef DMEM_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] cpu_addr;
  logic        cpu_rd, cpu_wr, cpu_ready, err, err_clr;
  logic        drv_en;
  logic [31:0] drv_data;
  wire  [31:0] cpu_data;
  assign cpu_data = drv_en ? drv_data : 'z;

  dmem_bridge_if #(.AW(32), .DW(32)) mbus ();

  dmem_bridge #(.AW(32), .DW(32), .TIMEOUT(255), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_data(cpu_data), .cpu_ready(cpu_ready), .bus(mbus), .err(err), .err_clr(err_clr)
  );

  logic [31:0] t_addr;
  logic        t_rd, t_ready, t_err, t_err_clr;
  wire  [31:0] t_data;

  dmem_bridge_if #(.AW(32), .DW(32)) tbus ();

  dmem_bridge #(.AW(32), .DW(32), .TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(t_addr), .cpu_rd(t_rd), .cpu_wr(1'b0),
    .cpu_data(t_data), .cpu_ready(t_ready), .bus(tbus), .err(t_err), .err_clr(t_err_clr)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Memory model for the main instance: acks on the dly-th cycle of bus_req
  // (dly 0 = never), with delay/data latched when the request appears.
  int unsigned resp_dly = 0, cur_dly = 0, rk = 0;
  logic [31:0] resp_data = '0, cur_data = '0;

  always @(negedge clk) begin
    if (mbus.bus_req) begin
      if (rk == 0) begin
        cur_dly  = resp_dly;
        cur_data = resp_data;
      end
      rk++;
      mbus.bus_ack   = (cur_dly != 0) && (rk == cur_dly);
      mbus.bus_rdata = cur_data;
    end else begin
      rk = 0;
      mbus.bus_ack = 1'b0;
    end
  end

  task automatic do_xact(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int unsigned dly, input logic clr, input bit drain,
                         output int unsigned low, output int unsigned req_idx,
                         output logic [31:0] g_addr, output logic [31:0] g_wdata,
                         output logic g_we, output logic [31:0] g_rdata,
                         output logic [31:0] g_rel);
    bit seen = 1'b0;
    bit got  = 1'b0;
    low = 0; req_idx = 0; g_addr = '0; g_wdata = '0; g_we = 1'b0; g_rdata = '0; g_rel = '0;
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; drv_data = wdata; drv_en = wr;
    err_clr = clr; resp_dly = dly; resp_data = rdata;
    for (int unsigned c = 0; c < 400 && !got; c++) begin
      if (c != 0) begin
        @(negedge clk);
        err_clr = 1'b0;
      end
      #1;
      if (mbus.bus_req && (mbus.bus_we == wr) && !seen) begin
        seen = 1'b1; req_idx = c;
        g_addr = mbus.bus_addr; g_wdata = mbus.bus_wdata; g_we = mbus.bus_we;
      end
      if (cpu_ready) begin
        got = 1'b1;
        g_rdata = cpu_data;
      end else begin
        low++;
      end
    end
    chk("ready_seen", {31'd0, got}, 32'd1);
    if (drain) begin
      @(negedge clk);
      cpu_rd = 1'b0; cpu_wr = 1'b0; drv_en = 1'b0; err_clr = 1'b0;
      #1 g_rel = cpu_data;
      for (int unsigned c = 0; c < 400 && mbus.bus_req; c++) @(negedge clk);
      #1 chk("bus_drained", {31'd0, mbus.bus_req}, 32'd0);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    int unsigned dly;
    logic [31:0] e_addr;
    logic        e_we;
    int unsigned e_low;
    logic        e_err;
  } vec_t;

  vec_t vt[6];

  int unsigned low, ridx, n, k;
  logic [31:0] ga, gw, gr, rel;
  logic        gwe;
  bit          got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vt[0] = '{rd:1'b1, wr:1'b0, addr:32'h104, wdata:32'h0, rdata:32'hCAFEF00D, dly:1,
              e_addr:32'h104, e_we:1'b0, e_low:2, e_err:1'b0};
    vt[1] = '{rd:1'b0, wr:1'b1, addr:32'h203, wdata:32'h12345678, rdata:32'h0, dly:5,
              e_addr:32'h200, e_we:1'b1, e_low:(POSTED ? 1 : 6), e_err:1'b0};
    vt[2] = '{rd:1'b1, wr:1'b0, addr:32'hFFFFFFFF, wdata:32'h0, rdata:32'h00000001, dly:3,
              e_addr:32'hFFFFFFFC, e_we:1'b0, e_low:4, e_err:1'b0};
    vt[3] = '{rd:1'b0, wr:1'b1, addr:32'h10, wdata:32'hA5A5A5A5, rdata:32'h0, dly:1,
              e_addr:32'h10, e_we:1'b1, e_low:(POSTED ? 1 : 2), e_err:1'b0};
    vt[4] = '{rd:1'b1, wr:1'b1, addr:32'h22, wdata:32'h5555AAAA, rdata:32'h0, dly:2,
              e_addr:32'h20, e_we:1'b1, e_low:(POSTED ? 1 : 3), e_err:1'b1};
    vt[5] = '{rd:1'b1, wr:1'b0, addr:32'h8, wdata:32'h0, rdata:32'h80000000, dly:2,
              e_addr:32'h8, e_we:1'b0, e_low:3, e_err:1'b0};

    rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; drv_en = 1'b0; drv_data = '0;
    err_clr = 1'b0; t_rd = 1'b0; t_addr = '0; t_err_clr = 1'b0;
    tbus.bus_ack = 1'b0; tbus.bus_rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
    chk("rst_req",   {31'd0, mbus.bus_req}, 32'd0);
    chk("rst_we",    {31'd0, mbus.bus_we}, 32'd0);
    chk("rst_addr",  mbus.bus_addr, 32'd0);
    chk("rst_wdata", mbus.bus_wdata, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);

    foreach (vt[i]) begin
      do_xact(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].dly,
              1'b0, 1'b1, low, ridx, ga, gw, gwe, gr, rel);
      chk($sformatf("v%0d_addr", i), ga, vt[i].e_addr);
      chk($sformatf("v%0d_we", i), {31'd0, gwe}, {31'd0, vt[i].e_we});
      chk($sformatf("v%0d_ready_low", i), low, vt[i].e_low);
      if (vt[i].e_we) begin
        chk($sformatf("v%0d_wdata", i), gw, vt[i].wdata);
      end else begin
        chk($sformatf("v%0d_rdata", i), gr, vt[i].rdata);
        chk($sformatf("v%0d_released", i), {31'd0, rel !== vt[i].rdata}, 32'd1);
      end
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vt[i].e_err});
      if (vt[i].e_err) begin
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        #1 chk($sformatf("v%0d_err_clr", i), {31'd0, err}, 32'd0);
      end
    end

    // err_clr in the same cycle as an illegal rd&wr request: set wins.
    do_xact(1'b1, 1'b1, 32'h30, 32'h77, 32'h0, 2, 1'b1, 1'b1, low, ridx, ga, gw, gwe, gr, rel);
    chk("set_beats_clr", {31'd0, err}, 32'd1);

    // Reset while BUSY: bus_req drops asynchronously, err is cleared.
    @(negedge clk); cpu_rd = 1'b1; cpu_addr = 32'h80; resp_dly = 0;
    @(negedge clk); @(negedge clk);
    #1 chk("req_before_rst", {31'd0, mbus.bus_req}, 32'd1);
    rst_n = 1'b0;
    #1 chk("req_async_drop", {31'd0, mbus.bus_req}, 32'd0);
    cpu_rd = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", {31'd0, cpu_ready}, 32'd1);
    chk("post_rst_err",   {31'd0, err}, 32'd0);
    chk("post_rst_req",   {31'd0, mbus.bus_req}, 32'd0);

    // TIMEOUT=4 read with no ack.
    @(negedge clk); t_rd = 1'b1; t_addr = 32'h40;
    n = 0; got = 1'b0; gr = '0;
    for (int unsigned c = 0; c < 20 && !got; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (tbus.bus_req) n++;
      if (t_ready) begin got = 1'b1; gr = t_data; end
    end
    chk("to_done",     {31'd0, got}, 32'd1);
    chk("to_req_cyc",  n, 32'd4);
    chk("to_data",     gr, 32'hDEADBEEF);
    chk("to_err",      {31'd0, t_err}, 32'd1);
    @(negedge clk); t_rd = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("to_err_sticky", {31'd0, t_err}, 32'd1);
    @(negedge clk); t_err_clr = 1'b1;
    @(negedge clk); t_err_clr = 1'b0;
    #1 chk("to_err_clr", {31'd0, t_err}, 32'd0);

    // Ack on the expiry cycle: data returned, no error.
    @(negedge clk); t_rd = 1'b1; t_addr = 32'h44;
    k = 0; got = 1'b0; gr = '0;
    for (int unsigned c = 0; c < 20 && !got; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (t_ready) begin got = 1'b1; gr = t_data; end
      if (tbus.bus_req) k++;
      tbus.bus_ack   = tbus.bus_req && (k == 4);
      tbus.bus_rdata = 32'h600DCAFE;
    end
    chk("exp_ack_done", {31'd0, got}, 32'd1);
    chk("exp_ack_cyc",  k, 32'd4);
    chk("exp_ack_data", gr, 32'h600DCAFE);
    chk("exp_ack_err",  {31'd0, t_err}, 32'd0);
    @(negedge clk); t_rd = 1'b0; tbus.bus_ack = 1'b0;

    // Stray ack while idle is ignored.
    @(negedge clk); tbus.bus_ack = 1'b1; tbus.bus_rdata = 32'h12121212;
    @(negedge clk); tbus.bus_ack = 1'b0;
    #1;
    chk("stray_req",   {31'd0, tbus.bus_req}, 32'd0);
    chk("stray_ready", {31'd0, t_ready}, 32'd1);
    chk("stray_nodrv", {31'd0, t_data !== 32'h600DCAFE}, 32'd1);
    chk("stray_err",   {31'd0, t_err}, 32'd0);

`ifdef DMEM_POSTED_WR_EN
    // Posted write followed immediately by a read that must wait for the drain.
    do_xact(1'b0, 1'b1, 32'h300, 32'h11112222, 32'h0, 3, 1'b0, 1'b0, low, ridx, ga, gw, gwe, gr, rel);
    chk("pw_wr_low",   low, 32'd1);
    chk("pw_wr_addr",  ga, 32'h300);
    chk("pw_wr_wdata", gw, 32'h11112222);
    do_xact(1'b1, 1'b0, 32'h304, 32'h0, 32'h33334444, 1, 1'b0, 1'b1, low, ridx, ga, gw, gwe, gr, rel);
    chk("pw_rd_req_idx", ridx, 32'd3);
    chk("pw_rd_low",     low, 32'd4);
    chk("pw_rd_addr",    ga, 32'h304);
    chk("pw_rd_data",    gr, 32'h33334444);
    chk("pw_err",        {31'd0, err}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
